seq_signed_divider_16x8: RTL
============================

Name: seq_signed_divider_16x8

Overview:
- Iterative restoring divider: signed 16-bit dividend by signed 8-bit divisor, one quotient bit per clock.
- Performs the inverse of the existing 8x8 Booth/Wallace multiplier on the same datapath widths.
- Result is truncated toward zero, matching Verilog / and %.
- Valid/ready handshake on the input and output sides; sits beside the multiplier in the arithmetic unit.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width; also the iteration count.
- DIVISOR_W, 8, divisor and remainder width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- dividend  in  DIVIDEND_W  signed dividend
- divisor  in  DIVISOR_W  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  DIVIDEND_W  signed quotient
- remainder  out  DIVISOR_W  signed remainder, same sign as dividend (or zero)
- div_by_zero  out  1  divisor was 0
- overflow  out  1  dividend = -2^(DIVIDEND_W-1) and divisor = -1
- busy  out  1  state != IDLE

Behaviour:
- Reset: async on rst_n low. State = IDLE, iteration counter = 0, all datapath registers = 0.
  - Outputs in reset: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, busy=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge (the accept edge), register the following: |dividend| (DIVIDEND_W unsigned), |divisor| (DIVISOR_W unsigned), dividend sign, quotient sign (XOR of operand signs), and the overflow flag.
  - divisor==0 → set div_by_zero and go to DONE. quotient=16'hFFFF, remainder=0. out_valid is high after the accept edge (latency 1).
  - Otherwise → CALC, counter=DIVIDEND_W-1.
- CALC:
  - Each cycle: shift partial remainder (DIVISOR_W+1 bits) left, bringing in the next dividend MSB, and trial-subtract |divisor|.
    - Non-negative trial → keep it and shift quotient bit 1.
    - Negative trial → restore and shift quotient bit 0.
  - Counter decrements each cycle. The edge with counter==0 goes to FIX (DIVIDEND_W CALC cycles).
- FIX:
  - Negate the quotient magnitude if the quotient sign is set.
  - Negate the remainder magnitude if the dividend sign is set.
  - Truncate each to its port width, then go to DONE.
- DONE:
  - out_valid=1.
  - quotient, remainder and flags are held stable while out_ready=0.
  - out_valid & out_ready at an edge → IDLE.
- Latency, normal path: out_valid rises after the 18th edge counting the accept edge as the 1st (1 accept + 16 CALC + 1 FIX).
- Throughput: one operation per 19 cycles minimum. in_ready is high only in IDLE, so there is no accept in the same cycle as output handoff.
- Operand changes after the accept edge are ignored.
- Overflow case (-32768 / -1):
  - Follows the normal path; quotient=16'h8000, remainder=0, overflow=1.
- Width rules:
  - |divisor| up to 128 fits in DIVISOR_W unsigned; the partial remainder needs DIVISOR_W+1 bits.
  - |dividend| up to 32768 fits in DIVIDEND_W unsigned.
  - The final |remainder| is at most 127, so it fits signed DIVISOR_W.
- Flags are cleared on every new accept.
- rst_n low mid-CALC/FIX/DONE: immediate return to the reset values above. The in-flight result is discarded; no out_valid is produced for it.

Decomposition:
- Package div_pkg holds:
  - state enum: IDLE, CALC, FIX, DONE
  - default widths DIVIDEND_W=16, DIVISOR_W=8
  - counter width $clog2(DIVIDEND_W)
  - DBZ_QUOTIENT = all ones
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside the CALC datapath.

Test Plan:
- 100 / 7, out_ready=1 → quotient=14, remainder=2, flags 0; out_valid after exactly 18 edges from accept.
- -100 / 7 → quotient=16'hFFF2 (-14), remainder=8'hFE (-2). 100 / -7 → quotient=-14, remainder=2.
- -32768 / -1 → quotient=16'h8000, remainder=0, overflow=1. -32768 / -128 → quotient=256, remainder=0, overflow=0.
- 1234 / 0 → div_by_zero=1, quotient=16'hFFFF, remainder=0; out_valid after 1 edge; the next operation 50/5 gives 10, 0 with div_by_zero=0.
- Backpressure: 1000 / 9 with out_ready=0 for 5 cycles → quotient=111 and remainder=1 stable, in_ready=0 throughout. Release → IDLE next edge, in_ready=1.
- rst_n pulsed low during the 8th CALC cycle → in_ready=1, busy=0 and out_valid=0 immediately. A fresh 77 / -3 then yields quotient=-25, remainder=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential signed divider.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int CNT_W          = $clog2(DEF_DIVIDEND_W);

  localparam logic [DEF_DIVIDEND_W-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] dvs_abs,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {2'b00, dvs_abs};
    // A borrow out of the top bit means the trial went negative: restore.
    q_bit   = ~trial[DIVISOR_W+1];
    rem_out = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/seq_signed_divider_16x8.sv
// Iterative signed restoring divider: one quotient bit per clock, results
// truncated toward zero, valid/ready on both sides.
module seq_signed_divider_16x8
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CW = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  state_t state_reg, state_next;

  logic [CW-1:0]         cnt_reg;
  logic [DIVIDEND_W-1:0] dvd_reg;
  logic [DIVISOR_W-1:0]  dvs_reg;
  logic [DIVISOR_W:0]    rem_reg;
  logic [DIVIDEND_W-1:0] quo_reg;
  logic                  neg_q_reg;
  logic                  neg_r_reg;
  logic                  ovf_reg;
  logic                  dbz_reg;
  logic [DIVIDEND_W-1:0] quotient_reg;
  logic [DIVISOR_W-1:0]  remainder_reg;

  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W-1:0]  dvs_abs;
  logic                  dvs_zero;
  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  // Negating the most negative value wraps onto itself, which is exactly
  // its magnitude when read back as unsigned.
  assign dvd_abs  = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign dvs_abs  = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
  assign dvs_zero = (divisor == '0);

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (rem_reg),
    .dvd_bit (dvd_reg[DIVIDEND_W-1]),
    .dvs_abs (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = dvs_zero ? DONE : CALC;
      CALC: if (cnt_reg == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dvd_reg       <= dvd_abs;
            dvs_reg       <= dvs_abs;
            rem_reg       <= '0;
            quo_reg       <= '0;
            neg_q_reg     <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_r_reg     <= dividend[DIVIDEND_W-1];
            ovf_reg       <= (dividend == MOST_NEG) && (divisor == '1);
            dbz_reg       <= dvs_zero;
            quotient_reg  <= dvs_zero ? DBZ_QUOTIENT[DIVIDEND_W-1:0] : '0;
            remainder_reg <= '0;
            cnt_reg       <= CW'(DIVIDEND_W - 1);
          end
        end
        CALC: begin
          rem_reg <= step_rem;
          quo_reg <= {quo_reg[DIVIDEND_W-2:0], step_q};
          dvd_reg <= {dvd_reg[DIVIDEND_W-2:0], 1'b0};
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        FIX: begin
          // The remainder magnitude is below |divisor| <= 2^(DIVISOR_W-1).
          quotient_reg  <= neg_q_reg ? -quo_reg : quo_reg;
          remainder_reg <= neg_r_reg ? -rem_reg[DIVISOR_W-1:0] : rem_reg[DIVISOR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule
